// File: rtl/sys_defs.sv
// Shared types for the decode, reservation-station and issue stages.
// Holds sizing constants plus the inter-stage packet structs.
package sys_defs;

  localparam int RS_SIZE     = 8;
  localparam int PHYS_REG_SZ = 64;
  localparam int TAG_W       = $clog2(PHYS_REG_SZ);
  localparam int CNT_W       = $clog2(RS_SIZE + 1);
  localparam int ROB_SZ      = 32;
  localparam int ROB_W       = $clog2(ROB_SZ);

  typedef logic [TAG_W-1:0] TAG;

  typedef struct packed {
    logic [31:0]      inst;
    logic [31:0]      PC;
    logic [31:0]      NPC;
    TAG               t;
    TAG               t1;
    TAG               t2;
    logic             t1_ready;
    logic             t2_ready;
    logic [ROB_W-1:0] rob_idx;
    logic [3:0]       alu_func;
    logic             rd_mem;
    logic             wr_mem;
    logic             cond_branch;
    logic             uncond_branch;
    logic             halt;
    logic             illegal;
    logic             valid;
  } DECODER_PACKET;

  typedef struct packed {
    DECODER_PACKET decoder_packet;
    logic          issue_en;
  } RS_IS_PACKET;

  function automatic logic tag_hit(logic v, TAG a, TAG b);
    return v && (a == b);
  endfunction

endpackage

// File: rtl/rs_psel.sv
// Lowest-index-first priority selector.
// Produces a one-hot grant and an any-request flag.
module rs_psel #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & (~req + N'(1));
  assign any = |req;

endmodule

// File: rtl/rs_station.sv
// Reservation station: holds renamed ops until both sources are
// ready, wakes them from the CDB and issues one per cycle.
module rs_station
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             dispatch_en,
  input  DECODER_PACKET    dispatch_packet,
  input  logic             cdb_valid,
  input  TAG               cdb_tag,
  input  logic             issue_stall,
  output RS_IS_PACKET      rs_is_packet,
  output logic [CNT_W-1:0] free_count,
  output logic             full
);

  logic [RS_SIZE-1:0] valid;
  logic [RS_SIZE-1:0] r1;
  logic [RS_SIZE-1:0] r2;
  DECODER_PACKET      pkt [RS_SIZE];

  logic [RS_SIZE-1:0] free_req;
  logic [RS_SIZE-1:0] free_gnt;
  logic               free_any;
  logic [RS_SIZE-1:0] iss_req;
  logic [RS_SIZE-1:0] iss_gnt;
  logic               iss_any;
  logic               issue_en;
  logic               do_disp;
  logic               d_r1;
  logic               d_r2;
  DECODER_PACKET      sel_pkt;

  assign free_req = ~valid;
  assign iss_req  = valid & r1 & r2;

  rs_psel #(.N(RS_SIZE)) u_free_sel (
    .req (free_req),
    .gnt (free_gnt),
    .any (free_any)
  );

  rs_psel #(.N(RS_SIZE)) u_iss_sel (
    .req (iss_req),
    .gnt (iss_gnt),
    .any (iss_any)
  );

  always_comb begin
    free_count = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!valid[i]) free_count = free_count + CNT_W'(1);
    end
  end

  assign full     = !free_any;
  assign issue_en = iss_any && !issue_stall && !squash;
  assign do_disp  = dispatch_en && free_any;

  // A same-cycle broadcast of a source tag counts as ready.
  assign d_r1 = dispatch_packet.t1_ready
             | tag_hit(cdb_valid, cdb_tag, dispatch_packet.t1);
  assign d_r2 = dispatch_packet.t2_ready
             | tag_hit(cdb_valid, cdb_tag, dispatch_packet.t2);

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (iss_gnt[i]) sel_pkt = pkt[i];
    end
  end

  assign rs_is_packet = {sel_pkt, issue_en};

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (issue_en && iss_gnt[i]) valid[i] <= 1'b0;
        if (valid[i] && tag_hit(cdb_valid, cdb_tag, pkt[i].t1))
          r1[i] <= 1'b1;
        if (valid[i] && tag_hit(cdb_valid, cdb_tag, pkt[i].t2))
          r2[i] <= 1'b1;
        if (do_disp && free_gnt[i]) begin
          valid[i] <= 1'b1;
          pkt[i]   <= dispatch_packet;
          r1[i]    <= d_r1;
          r2[i]    <= d_r2;
        end
      end
    end
  end

endmodule
